tilemap_scanner: RTL
====================

Name: tilemap_scanner

Overview:
- Upstream stage of the tile drawer; walks a tilemap grid row-major and issues one tile-draw job per cell.
- Per cell: reads a tile index from map RAM, converts it to a tile-ROM byte address and an 8x8 screen position, then drives the drawer's draw/active handshake.
- Used for full-background redraws at level load; the drawer renders each tile onto the shared VGA bus.

Parameters:
- MAP_COLS, 20, tiles per row (160 px / 8)
- MAP_ROWS, 15, tile rows (120 px / 8)
- NUM_TILES, 21, valid tile indices 0..NUM_TILES-1 (21*192 <= 4096 ROM bytes)
- TILE_BYTES, 192, ROM bytes per tile (64 px * 3 bytes RGB)
- TILE_BASE, 0, ROM byte address of tile 0
- SKIP_EMPTY, 0, when 1, cells holding index 0 are skipped without drawing

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin full-map scan; sampled only in IDLE
- map_address  out  9  map RAM read address (row*MAP_COLS + col)
- map_data  in  5  tile index from map RAM; valid 2 cycles after map_address changes
- tile_address  out  12  ROM byte address of the tile, to drawer
- x_pos  out  8  column pixel origin (col*8), to drawer
- y_pos  out  8  row pixel origin (row*8), to drawer
- draw  out  1  draw request to drawer
- active  in  1  drawer busy flag
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last cell
- bad_index  out  1  sticky; set on any out-of-range index, cleared by next accepted start

Behaviour:
- Reset (async, resetn=0): state IDLE; col=row=0; all outputs 0; draw drops immediately even mid-handshake.
- States:
  - IDLE: on start=1, clear bad_index, col=row=0, go FETCH; busy=1 from the next cycle.
  - FETCH: drive map_address; go WAIT.
  - WAIT: one cycle; go LATCH.
  - LATCH: register map_data (2-cycle read latency satisfied).
    - If idx >= NUM_TILES: substitute 0, set bad_index.
    - If SKIP_EMPTY and the latched idx==0: go ADVANCE.
    - Otherwise: go REQUEST.
  - REQUEST: tile_address = TILE_BASE + idx*TILE_BYTES, truncated to 12 bits; x_pos=col*8; y_pos=row*8. All registered, held stable through WAIT_DRAW. draw=1 held until active=1 is sampled, then go WAIT_DRAW.
  - WAIT_DRAW: draw=0; stay while active=1; on active=0 go ADVANCE.
  - ADVANCE:
    - col==MAP_COLS-1 and row==MAP_ROWS-1: go DONE.
    - col==MAP_COLS-1 only: col=0, row+1, go FETCH.
    - Otherwise: col+1, go FETCH.
  - DONE: done=1 for exactly one cycle; busy=0 from the next cycle; go IDLE.
- Handshake rules:
  - draw is never asserted while active=1 at REQUEST entry. If active is already high at REQUEST entry (bus owned by another master), wait for active=0 with draw low, then assert draw.
  - tile_address, x_pos and y_pos never change while draw=1 or during WAIT_DRAW.
- Map address: computed incrementally (+1 per cell); map_address increases monotonically 0..MAP_COLS*MAP_ROWS-1 and wraps to 0 only on a new start.
- start while busy: ignored.
- start and done in the same cycle: start ignored; it must be reasserted.
- Widths: x_pos/y_pos are 8-bit, so max origin is 152/112. The idx*TILE_BYTES product is computed 12-bit; TILE_BASE overflow wraps.
- Per-cell overhead excluding the drawer: 5 cycles (FETCH, WAIT, LATCH, REQUEST min 1, ADVANCE).

Decomposition:
- Shared package (tile_pkg): TILE_PX=8, TILE_BYTES=192, screen width/height 160/120, and the scanner state encoding as localparams. The drawer later reuses TILE_BYTES.
- One sub-module: tile_addr_calc. Combinational idx -> tile_address with range check and bad flag, implemented as shift-add (idx<<7 + idx<<6).

Test Plan:
- Reset mid-REQUEST (draw=1), resetn low for 1 cycle -> draw=0 within the same cycle; busy=0; map_address=0.
- 2x2 map (MAP_COLS=MAP_ROWS=2) with indices {1,2,3,4}, drawer model raising active 1 cycle after draw and holding it 10 cycles -> four jobs in order:
  - (tile_address,x,y) = (192,0,0), (384,8,0), (576,0,8), (768,8,8)
  - then a single done pulse.
- Cell index 25 with NUM_TILES=21 -> tile_address=0, bad_index=1 held until the next start; the scan still completes.
- SKIP_EMPTY=1, map {0,5,0,0} -> exactly one draw, with tile_address=960, x=8, y=0; done follows.
- active held high by another master at REQUEST entry for 20 cycles -> draw stays 0 until active falls, then asserts; no job is lost.
- start pulsed during busy and in the done cycle -> ignored; a second start pulse in IDLE runs a full second scan starting at map_address=0.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared tile constants and the scanner state encoding.
package tile_pkg;
    localparam int TILE_PX    = 8;
    localparam int TILE_BYTES = 192;   // 64 px * 3 bytes RGB
    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_WAIT      = 3'd2;
    localparam logic [2:0] ST_LATCH     = 3'd3;
    localparam logic [2:0] ST_REQUEST   = 3'd4;
    localparam logic [2:0] ST_WAIT_DRAW = 3'd5;
    localparam logic [2:0] ST_ADVANCE   = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_FETCH     = ST_FETCH,
        S_WAIT      = ST_WAIT,
        S_LATCH     = ST_LATCH,
        S_REQUEST   = ST_REQUEST,
        S_WAIT_DRAW = ST_WAIT_DRAW,
        S_ADVANCE   = ST_ADVANCE,
        S_DONE      = ST_DONE
    } scan_state_t;
endpackage

// File: rtl/tile_addr_calc.sv
// Tile index -> ROM byte address, with range check. Purely combinational.
module tile_addr_calc import tile_pkg::*; #(
    parameter int NUM_TILES  = 21,
    parameter int TILE_BYTES = tile_pkg::TILE_BYTES,
    parameter int TILE_BASE  = 0
) (
    input  logic [4:0]  idx,
    output logic [11:0] tile_address,
    output logic        bad,
    output logic        empty
);
    logic [4:0]  idx_eff;
    logic [11:0] offset;

    // Out-of-range indices are replaced by tile 0 and flagged.
    always_comb begin
        bad     = ({27'd0, idx} >= NUM_TILES);
        idx_eff = bad ? 5'd0 : idx;
        empty   = (idx_eff == 5'd0);
    end

    generate
        if (TILE_BYTES == 192) begin : g_shift_add
            // 192 = 128 + 64; product wraps at 12 bits.
            assign offset = ({7'd0, idx_eff} << 7) + ({7'd0, idx_eff} << 6);
        end else begin : g_mul
            assign offset = 12'({27'd0, idx_eff} * TILE_BYTES);
        end
    endgenerate

    assign tile_address = offset + 12'(TILE_BASE);
endmodule

// File: rtl/tilemap_scanner.sv
// Walks the tilemap row-major and hands one draw job per cell to the drawer.
module tilemap_scanner import tile_pkg::*; #(
    parameter int MAP_COLS   = 20,
    parameter int MAP_ROWS   = 15,
    parameter int NUM_TILES  = 21,
    parameter int TILE_BYTES = tile_pkg::TILE_BYTES,
    parameter int TILE_BASE  = 0,
    parameter int SKIP_EMPTY = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic [8:0]  map_address,
    input  logic [4:0]  map_data,
    output logic [11:0] tile_address,
    output logic [7:0]  x_pos,
    output logic [7:0]  y_pos,
    output logic        draw,
    input  logic        active,
    output logic        busy,
    output logic        done,
    output logic        bad_index
);
    scan_state_t state, state_nxt;
    logic [4:0]  col;
    logic [3:0]  row;
    logic [11:0] calc_addr;
    logic        calc_bad, calc_empty;
    logic        last_col, last_row;

    // map_data is consumed straight out of the read port during LATCH.
    tile_addr_calc #(
        .NUM_TILES (NUM_TILES),
        .TILE_BYTES(TILE_BYTES),
        .TILE_BASE (TILE_BASE)
    ) u_calc (
        .idx         (map_data),
        .tile_address(calc_addr),
        .bad         (calc_bad),
        .empty       (calc_empty)
    );

    assign last_col = (col == 5'(MAP_COLS - 1));
    assign last_row = (row == 4'(MAP_ROWS - 1));

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE:      if (start) state_nxt = S_FETCH;
            S_FETCH:     state_nxt = S_WAIT;
            S_WAIT:      state_nxt = S_LATCH;
            S_LATCH:     state_nxt = (SKIP_EMPTY != 0 && calc_empty) ? S_ADVANCE : S_REQUEST;
            S_REQUEST:   if (draw && active) state_nxt = S_WAIT_DRAW;
            S_WAIT_DRAW: if (!active) state_nxt = S_ADVANCE;
            S_ADVANCE:   state_nxt = (last_col && last_row) ? S_DONE : S_FETCH;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Cell counters, job registers and the draw handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col          <= '0;
            row          <= '0;
            map_address  <= '0;
            tile_address <= '0;
            x_pos        <= '0;
            y_pos        <= '0;
            draw         <= 1'b0;
            bad_index    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    col         <= '0;
                    row         <= '0;
                    map_address <= '0;
                    bad_index   <= 1'b0;
                end
                S_LATCH: begin
                    if (calc_bad) bad_index <= 1'b1;
                    if (state_nxt == S_REQUEST) begin
                        tile_address <= calc_addr;
                        x_pos        <= {col, 3'b000};
                        y_pos        <= 8'({row, 3'b000});
                        // Someone else owns the bus: hold off until it is released.
                        draw         <= !active;
                    end
                end
                S_REQUEST: begin
                    if (draw && active)        draw <= 1'b0;
                    else if (!draw && !active) draw <= 1'b1;
                end
                S_ADVANCE: if (!(last_col && last_row)) begin
                    map_address <= map_address + 9'd1;
                    if (last_col) begin
                        col <= '0;
                        row <= row + 4'd1;
                    end else begin
                        col <= col + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
